// File: rtl/beat_track_if.sv
// Bundle of control and status signals between a beat track controller and
// whatever drives it (keyboard scanner, UI logic, or a testbench).
//
// Handshake: there is no back-pressure. Inputs are sampled on every rising clk
// edge. tick is a one-cycle strobe, and clear is a one-cycle pulse. rec_en and
// play_en are levels. note_out is meaningful only while note_valid is high.
// note_valid is high in PLAY_LOAD/PLAY_RUN while the active track is
// non-empty, and the consumer takes note_out as the live key on every cycle
// that note_valid is high.
interface beat_track_if #(
  parameter int DEPTH = 64
);
  localparam int LEN_W = $clog2(DEPTH) + 1;

  logic             tick;
  logic [6:0]       ascii;
  logic             rec_en;
  logic             play_en;
  logic             sel_b;
  logic             clear;
  logic [6:0]       note_out;
  logic             note_valid;
  logic             rec_full;
  logic [2:0]       state;
  logic [LEN_W-1:0] len_a;
  logic [LEN_W-1:0] len_b;

  modport master (
    output tick, ascii, rec_en, play_en, sel_b, clear,
    input  note_out, note_valid, rec_full, state, len_a, len_b
  );

  modport slave (
    input  tick, ascii, rec_en, play_en, sel_b, clear,
    output note_out, note_valid, rec_full, state, len_a, len_b
  );
endinterface

// File: rtl/beat_track_controller.sv
// Two-track run-length beat recorder/looper. While recording, each key held
// across ticks becomes one {key, count} entry. A run that reaches CNT_MAX is
// split into several same-key entries. Playback replays the selected track in
// a loop, holding each key for exactly count ticks.
module beat_track_controller #(
  parameter int DEPTH = 64,
  parameter int CNT_W = 16
) (
  input  logic         clk,
  input  logic         reset,
  beat_track_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LEN_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(DEPTH);

  typedef struct packed {
    logic [6:0]       key;
    logic [CNT_W-1:0] cnt;
  } entry_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REC   = 3'd1,
    S_FLUSH = 3'd2,
    S_PLOAD = 3'd3,
    S_PRUN  = 3'd4
  } state_t;

  // Track storage. It has no reset, because a zero length makes stale
  // entries unreachable.
  entry_t mem_a [DEPTH];
  entry_t mem_b [DEPTH];

  state_t           state_q, state_d;
  logic             active_q, active_d;     // 1 = track B latched on leaving IDLE
  logic [LEN_W-1:0] len_a_q, len_a_d;
  logic [LEN_W-1:0] len_b_q, len_b_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [6:0]       run_key_q, run_key_d;
  logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
  logic             run_valid_q, run_valid_d;
  logic             rec_full_q, rec_full_d;
  logic [6:0]       cur_key_q, cur_key_d;
  logic [CNT_W-1:0] remain_q, remain_d;
  logic [6:0]       note_q, note_d;         // key shown outside PLAY_RUN (held through LOAD)

  logic             wr_en;
  logic             wr_b;
  logic [PTR_W-1:0] wr_addr;
  entry_t           wr_data;
  entry_t           rd_entry;
  logic [LEN_W-1:0] act_len;
  logic [LEN_W-1:0] len_inc;
  logic [LEN_W-1:0] rd_inc;

  assign act_len  = active_q ? len_b_q : len_a_q;
  assign len_inc  = act_len + LEN_W'(1);
  assign rd_inc   = {1'b0, rd_ptr_q} + LEN_W'(1);
  assign rd_entry = active_q ? mem_b[rd_ptr_q] : mem_a[rd_ptr_q];

  // State register. Reset is asynchronous, so the FSM drops to IDLE at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Datapath registers: lengths, pointers, pending run, and playback run.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_q    <= 1'b0;
      len_a_q     <= '0;
      len_b_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      run_key_q   <= '0;
      run_cnt_q   <= '0;
      run_valid_q <= 1'b0;
      rec_full_q  <= 1'b0;
      cur_key_q   <= '0;
      remain_q    <= '0;
      note_q      <= '0;
    end else begin
      active_q    <= active_d;
      len_a_q     <= len_a_d;
      len_b_q     <= len_b_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      run_key_q   <= run_key_d;
      run_cnt_q   <= run_cnt_d;
      run_valid_q <= run_valid_d;
      rec_full_q  <= rec_full_d;
      cur_key_q   <= cur_key_d;
      remain_q    <= remain_d;
      note_q      <= note_d;
    end
  end

  // Synchronous write port shared by both tracks.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (wr_b) mem_b[wr_addr] <= wr_data;
      else      mem_a[wr_addr] <= wr_data;
    end
  end

  // Next-state and datapath-update logic for all five states.
  always_comb begin
    state_d     = state_q;
    active_d    = active_q;
    len_a_d     = len_a_q;
    len_b_d     = len_b_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    run_key_d   = run_key_q;
    run_cnt_d   = run_cnt_q;
    run_valid_d = run_valid_q;
    rec_full_d  = rec_full_q;
    cur_key_d   = cur_key_q;
    remain_d    = remain_q;
    note_d      = note_q;
    wr_en       = 1'b0;
    wr_b        = active_q;
    wr_addr     = wr_ptr_q;
    wr_data     = {run_key_q, run_cnt_q};

    unique case (state_q)
      S_IDLE: begin
        note_d = '0;
        if (bus.clear) begin
          if (bus.sel_b) len_b_d = '0;
          else           len_a_d = '0;
          rec_full_d = 1'b0;
        end
        if (bus.rec_en) begin
          state_d     = S_REC;
          active_d    = bus.sel_b;
          if (bus.sel_b) len_b_d = '0;
          else           len_a_d = '0;
          wr_ptr_d    = '0;
          run_valid_d = 1'b0;
          run_cnt_d   = '0;
          rec_full_d  = 1'b0;
        end else if (bus.play_en) begin
          state_d  = S_PLOAD;
          active_d = bus.sel_b;
          rd_ptr_d = '0;
        end
      end

      S_REC: begin
        // Dropping rec_en wins over a same-cycle tick, so that tick is not counted.
        if (!bus.rec_en) begin
          state_d = run_valid_q ? S_FLUSH : S_IDLE;
        end else if (bus.tick) begin
          if (!run_valid_q) begin
            run_key_d   = bus.ascii;
            run_cnt_d   = CNT_ONE;
            run_valid_d = 1'b1;
          end else if (bus.ascii == run_key_q && run_cnt_q != CNT_MAX) begin
            run_cnt_d = run_cnt_q + CNT_ONE;
          end else begin
            // Key change or saturated run: commit the entry and start a new run.
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (active_q) len_b_d = len_inc;
            else          len_a_d = len_inc;
            if (len_inc == FULL_LEN) begin
              rec_full_d  = 1'b1;
              run_valid_d = 1'b0;
              state_d     = S_IDLE;
            end else begin
              run_key_d = bus.ascii;
              run_cnt_d = CNT_ONE;
            end
          end
        end
      end

      S_FLUSH: begin
        if (act_len != FULL_LEN) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + PTR_W'(1);
          if (active_q) len_b_d = len_inc;
          else          len_a_d = len_inc;
        end
        run_valid_d = 1'b0;
        state_d     = S_IDLE;
      end

      S_PLOAD: begin
        if (!bus.play_en || act_len == '0) begin
          state_d = S_IDLE;
          note_d  = '0;
        end else begin
          cur_key_d = rd_entry.key;
          remain_d  = rd_entry.cnt;
          state_d   = S_PRUN;
        end
      end

      S_PRUN: begin
        // Remember the playing key so that PLAY_LOAD keeps showing it.
        note_d = cur_key_q;
        if (!bus.play_en) begin
          state_d = S_IDLE;
          note_d  = '0;
        end else if (bus.tick) begin
          if (remain_q > CNT_ONE) begin
            remain_d = remain_q - CNT_ONE;
          end else begin
            rd_ptr_d = (rd_inc == act_len) ? '0 : rd_ptr_q + PTR_W'(1);
            state_d  = S_PLOAD;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        note_d  = '0;
      end
    endcase
  end

  assign bus.note_out   = (state_q == S_PRUN) ? cur_key_q : note_q;
  assign bus.note_valid = (state_q == S_PLOAD || state_q == S_PRUN) && (act_len != '0);
  assign bus.rec_full   = rec_full_q;
  assign bus.state      = state_q;
  assign bus.len_a      = len_a_q;
  assign bus.len_b      = len_b_q;
endmodule

// File: tb/tb_beat_track_controller.sv
// Directed bench for beat_track_controller (DEPTH=4, CNT_W=4). Recording and
// playback are driven from the main process. Expected playback runs
// {key, ticks} go into exp_q, and a negedge monitor measures the runs the DUT
// plays and checks them against that queue.
module tb_beat_track_controller;
  localparam int DEPTH = 4;
  localparam int CNT_W = 4;
  localparam int W     = 7 + CNT_W;

  logic clk;
  logic reset;
  int   errors;
  int   checks;
  int   keys_used;

  logic [W-1:0] exp_q[$];
  logic [6:0]   key_q[$];

  // Monitor bookkeeping
  int           run_len;
  int           load_cnt;
  logic [6:0]   run_key;
  logic [6:0]   last_key;
  logic [W-1:0] exp_run;

  beat_track_if #(.DEPTH(DEPTH)) bus ();

  beat_track_controller #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(input int key, input int cnt);
    logic [6:0]       k;
    logic [CNT_W-1:0] c;
    k = 7'(key);
    c = CNT_W'(cnt);
    return {k, c};
  endfunction

  // Monitor: measures each played run and compares it with the scoreboard
  always @(negedge clk) begin
    if (reset || bus.state == 3'd0) begin
      run_len  = 0;
      load_cnt = 0;
      last_key = '0;
    end else if (bus.play_en) begin
      if (bus.state == 3'd3) begin
        if (run_len > 0) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL run_unexpected: got key %0d x%0d expected no run", run_key, run_len);
          end else begin
            exp_run = exp_q.pop_front();
            check("play_run", {run_key, run_len[CNT_W-1:0]}, exp_run);
            last_key = exp_run[W-1:CNT_W];
          end
          run_len = 0;
        end
        check("load_hold", bus.note_out, last_key);
        load_cnt++;
      end else if (bus.state == 3'd4) begin
        if (load_cnt != 0) begin
          check("load_cycles", load_cnt, 1);
          load_cnt = 0;
        end
        if (bus.tick) begin
          check("run_note_valid", bus.note_valid, 1);
          run_key = bus.note_out;
          run_len++;
        end
      end
    end
  end

  // Driver: record key_q onto a track. Drops rec_en early if the track fills.
  task automatic record(input logic sel, input logic both);
    bus.sel_b   = sel;
    bus.rec_en  = 1'b1;
    bus.play_en = both;
    bus.tick    = 1'b0;
    @(posedge clk); #1;
    check("rec_entry_state", bus.state, 1);
    bus.sel_b = ~sel;
    keys_used = 0;
    while (key_q.size() != 0 && bus.state == 3'd1) begin
      bus.ascii = key_q.pop_front();
      bus.tick  = 1'b1;
      keys_used++;
      @(posedge clk); #1;
    end
    key_q.delete();
    // Same key with tick, but rec_en low: this tick must not extend the run.
    bus.rec_en  = 1'b0;
    bus.play_en = 1'b0;
    bus.tick    = 1'b1;
    @(posedge clk); #1;
    bus.tick = 1'b0;
    for (int i = 0; i < 4 && bus.state != 3'd0; i++) begin
      @(posedge clk); #1;
    end
    check("rec_back_idle", bus.state, 0);
  endtask

  // Driver: loop-play a track until exp_q drains, optionally pulsing clear mid-play.
  task automatic play(input logic sel, input logic do_clear);
    int n;
    bus.sel_b   = sel;
    bus.play_en = 1'b1;
    bus.tick    = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
      bus.clear = (do_clear && n == 4);
    end
    bus.clear = 1'b0;
    check("play_drain_left", exp_q.size(), 0);
    exp_q.delete();
    bus.play_en = 1'b0;
    bus.tick    = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("play_stop_state", bus.state, 0);
    check("play_stop_note", bus.note_out, 0);
    check("play_stop_valid", bus.note_valid, 0);
  endtask

  // Main stimulus sequence and final report
  initial begin
    errors      = 0;
    checks      = 0;
    reset       = 1'b1;
    bus.tick    = 1'b0;
    bus.ascii   = '0;
    bus.rec_en  = 1'b0;
    bus.play_en = 1'b0;
    bus.sel_b   = 1'b0;
    bus.clear   = 1'b0;
    #1;
    check("reset_state", bus.state, 0);
    check("reset_note", bus.note_out, 0);
    check("reset_valid", bus.note_valid, 0);
    check("reset_rec_full", bus.rec_full, 0);
    check("reset_len_a", bus.len_a, 0);
    check("reset_len_b", bus.len_b, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    // Track A: 65,65,65,66,66 -> {65,3},{66,2}
    key_q = '{7'd65, 7'd65, 7'd65, 7'd66, 7'd66};
    record(1'b0, 1'b0);
    check("a_len", bus.len_a, 2);
    check("a_rec_full", bus.rec_full, 0);
    exp_q = '{mk(65, 3), mk(66, 2), mk(65, 3)};
    play(1'b0, 1'b0);

    // Track B: 20 ticks of 70 -> {70,15},{70,5}
    for (int i = 0; i < 20; i++) key_q.push_back(7'd70);
    record(1'b1, 1'b0);
    check("b_sat_len", bus.len_b, 2);
    check("b_sat_len_a_kept", bus.len_a, 2);
    exp_q = '{mk(70, 15), mk(70, 5), mk(70, 15)};
    play(1'b1, 1'b0);

    // Track A: alternating keys fill the track after the 4th write
    key_q = '{7'd1, 7'd2, 7'd1, 7'd2, 7'd1, 7'd2};
    record(1'b0, 1'b0);
    check("full_keys_taken", keys_used, 5);
    check("full_rec_full", bus.rec_full, 1);
    check("full_len_a", bus.len_a, 4);
    exp_q = '{mk(1, 1), mk(2, 1), mk(1, 1), mk(2, 1), mk(1, 1)};
    play(1'b0, 1'b0);
    check("full_sticky", bus.rec_full, 1);

    // rec_en and play_en together with sel_b=1 -> record track B
    key_q = '{7'd9, 7'd9};
    record(1'b1, 1'b1);
    check("both_len_b", bus.len_b, 1);
    check("both_len_a", bus.len_a, 4);
    check("both_rec_full", bus.rec_full, 0);
    exp_q = '{mk(9, 2), mk(9, 2)};
    play(1'b1, 1'b1);
    check("clear_in_play_ignored", bus.len_b, 1);

    // Clear A in IDLE; B untouched
    bus.sel_b = 1'b0;
    bus.clear = 1'b1;
    @(posedge clk); #1;
    bus.clear = 1'b0;
    check("clear_len_a", bus.len_a, 0);
    check("clear_len_b", bus.len_b, 1);
    check("clear_rec_full", bus.rec_full, 0);

    // Play an empty track: one LOAD cycle with no valid note, then IDLE
    bus.play_en = 1'b1;
    bus.tick    = 1'b1;
    @(posedge clk); #1;
    check("empty_load_state", bus.state, 3);
    check("empty_load_valid", bus.note_valid, 0);
    @(posedge clk); #1;
    check("empty_back_idle", bus.state, 0);
    bus.play_en = 1'b0;
    @(posedge clk); #1;

    // Asynchronous reset in the middle of PLAY_RUN on track B
    bus.sel_b   = 1'b1;
    bus.play_en = 1'b1;
    for (int i = 0; i < 4 && bus.state != 3'd4; i++) begin
      @(posedge clk); #1;
    end
    check("pre_reset_run", bus.state, 4);
    check("pre_reset_note", bus.note_out, 9);
    #1 reset = 1'b1;
    #1;
    check("async_reset_state", bus.state, 0);
    check("async_reset_note", bus.note_out, 0);
    check("async_reset_valid", bus.note_valid, 0);
    check("async_reset_len_a", bus.len_a, 0);
    check("async_reset_len_b", bus.len_b, 0);
    bus.play_en = 1'b0;
    bus.tick    = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check("post_reset_state", bus.state, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
